pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 96 +++++++++
 tb/tb_pipe_skid_reg.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline stage (main + skid register) with valid/ready handshakes.
// Optional back-pressure counter on port stall_cnt, enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_accept;
    logic              w_consume;

    // Handshake flags are decoded straight from the state register.
    assign in_ready  = (r_state != ST_TWO) && !flush;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_ONE;
                        r_main  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_state <= ST_TWO;
                        r_skid  <= in_data;
                    end else if (w_consume) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a consume can move the stage.
                    if (w_consume) begin
                        r_state <= ST_ONE;
                        r_main  <= r_skid;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles where a valid output is held back; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized and directed bench for pipe_skid_reg against a queue-based reference model.
// Exercises stall_cnt only when PIPE_STALL_CNT_EN is defined.
module tb_pipe_skid_reg;

    localparam int unsigned DATA_W = 64;
`ifdef PIPE_STALL_CNT_EN
    localparam int unsigned CNT_W  = 4;
`else
    localparam int unsigned CNT_W  = 16;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: held entries in FIFO order, plus the value left on out_data.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_hold;
    int                m_stall;

    pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic exp_valid();
        return m_q.size() > 0;
    endfunction

    function automatic logic exp_ready();
        return (m_q.size() < 2) && !flush;
    endfunction

    // Advance one clock edge and update the model from the inputs sampled at that edge.
    task automatic tick();
        logic acc;
        logic cons;
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_hold  = '0;
            m_stall = 0;
        end else begin
            if (m_q.size() > 0 && !out_ready && m_stall < (2 ** CNT_W) - 1)
                m_stall = m_stall + 1;
            if (flush) begin
                m_q.delete();
                m_hold = '0;
            end else begin
                acc  = in_valid && (m_q.size() < 2);
                cons = (m_q.size() > 0) && out_ready;
                if (cons) m_hold = m_q.pop_front();
                if (acc)  m_q.push_back(in_data);
                if (m_q.size() > 0) m_hold = m_q[0];
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_pass_through();
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        a = 64'h00000004_00000022;
        b = 64'h00000008_00000237;
        out_ready = 1'b1; in_valid = 1'b1; in_data = a;
        tick();
        in_data = b;
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== a) $display("FAIL pass_first got v=%0b d=%h want v=1 d=%h", out_valid, out_data, a);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== b) $display("FAIL pass_second got v=%0b d=%h want v=1 d=%h", out_valid, out_data, b);
        else n_pass++;
        tick();
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== b) $display("FAIL pass_drain got v=%0b d=%h want v=0 d=%h", out_valid, out_data, b);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        a = 64'h00000008_00000237;
        b = 64'h0000000E_0000039B;
        out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        tick();
        in_data = b;
        tick();
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== a)
            $display("FAIL bp_two got rdy=%0b v=%0b d=%h want rdy=0 v=1 d=%h", in_ready, out_valid, out_data, a);
        else n_pass++;
        tick();
        out_ready = 1'b1; in_valid = 1'b0;
        #1;
        n_total++;
        if (out_data !== a) $display("FAIL bp_stalled_hold got %h want %h", out_data, a);
        else n_pass++;
        tick();
        out_ready = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== b || in_ready !== 1'b1)
            $display("FAIL bp_release got v=%0b d=%h rdy=%0b want v=1 d=%h rdy=1", out_valid, out_data, in_ready, b);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic fill_two();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = {$urandom, $urandom};
        tick();
        in_data = {$urandom, $urandom};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        fill_two();
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 64'h1234_5678_9ABC_DEF0;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0b want 0", in_ready);
        else n_pass++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== '0) $display("FAIL flush_empty got v=%0b d=%h want v=0 d=0", out_valid, out_data);
        else n_pass++;
        tick();
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_no_emit got v=%0b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        fill_two();
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1)
            $display("FAIL rstmid_empty got v=%0b d=%h rdy=%0b want v=0 d=0 rdy=1", out_valid, out_data, in_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_total++;
            if (out_valid !== 1'b0 || out_data !== '0)
                $display("FAIL rstmid_stale cyc=%0d got v=%0b d=%h want v=0 d=0", i, out_valid, out_data);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom};
            #1;
            n_total++;
            if (out_valid !== exp_valid() || out_data !== m_hold || in_ready !== exp_ready())
                $display("FAIL random cyc=%0d got v=%0b d=%h rdy=%0b want v=%0b d=%h rdy=%0b",
                         i, out_valid, out_data, in_ready, exp_valid(), m_hold, exp_ready());
            else n_pass++;
`ifdef PIPE_STALL_CNT_EN
            n_total++;
            if (int'(stall_cnt) !== m_stall) $display("FAIL random_stall cyc=%0d got %0d want %0d", i, stall_cnt, m_stall);
            else n_pass++;
`endif
            tick();
        end
        idle_inputs();
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b1; in_data = 64'hA5A5_0000_0000_5A5A;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #1;
        n_total++;
        if (stall_cnt !== 4'd15) $display("FAIL stall_sat got %0d want 15", stall_cnt);
        else n_pass++;
        tick();
        #1;
        n_total++;
        if (stall_cnt !== 4'd15) $display("FAIL stall_hold got %0d want 15", stall_cnt);
        else n_pass++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_total++;
        if (stall_cnt !== 4'd15) $display("FAIL stall_flush got %0d want 15", stall_cnt);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (stall_cnt !== 4'd0) $display("FAIL stall_reset got %0d want 0", stall_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        m_hold  = '0;
        m_stall = 0;
        idle_inputs();
        #2;
        test_reset();
        test_pass_through();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
